// File: rtl/turf_register_master.sv
// TURF register bus initiator: one command in, one bus cycle with ack timeout, one response out.
// Optional TURF_MASTER_STATS_EN adds transaction/timeout counters.
module turf_register_master #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [27:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        en_o,
  output logic        wr_o,
  output logic [27:0] adr_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i
`ifdef TURF_MASTER_STATS_EN
  ,
  output logic [31:0] stat_txn_o,
  output logic [31:0] stat_tmo_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic        wr_q;
  logic [15:0] timer_q;
  logic        accept;
  logic        tmo_hit;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign tmo_hit = (timer_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = BUS;
      BUS:     if (ack_i || tmo_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so reset kills them at once.
  always_comb begin
    cmd_ready = rst_n && (state_q == IDLE);
    en_o      = (state_q == BUS);
    wr_o      = (state_q == BUS) && wr_q;
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      timer_q <= '0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      wr_q    <= cmd_wr;
      adr_o   <= cmd_adr;
      dat_o   <= cmd_dat;
      timer_q <= '0;
    end else if (state_q == BUS) begin
      if (ack_i) begin
        rsp_dat <= wr_q ? dat_o : dat_i;
        rsp_err <= 1'b0;
      end else if (tmo_hit) begin
        rsp_dat <= ERR_DATA;
        rsp_err <= 1'b1;
      end else begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

`ifdef TURF_MASTER_STATS_EN
  logic done;
  assign done = (state_q == BUS) && (ack_i || tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn_o <= '0;
      stat_tmo_o <= '0;
    end else if (done) begin
      stat_txn_o <= stat_txn_o + 32'd1;
      if (!ack_i) stat_tmo_o <= stat_tmo_o + 32'd1;
    end
  end
`endif

endmodule
